// File: rtl/sdram_dq_bank.sv
// SDRAM DQ pad bank: registered pad drive, DDR/single-rate capture FIFO and a W+1 bscan chain.
// Define SDRAM_DQ_BSCAN_EN to build the boundary-scan chain; otherwise bscan_so is a pass-through.
module sdram_dq_bank #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      pin_out,
    input  logic              pin_outen,
    input  logic              sdrmode,
    input  logic              hw_enb,
    input  logic              in_valid,
    input  logic [2*W-1:0]    in_data,
    input  logic              rd_en,
    output logic [2*W-1:0]    rd_data,
    output logic              rd_valid,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [LW-1:0]     fifo_level,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic [W-1:0]      pad_out,
    output logic [W-1:0]      pad_oe,
    input  logic              bscan_si,
    output logic              bscan_so,
    input  logic              bscan_clken,
    input  logic              bscan_capture,
    input  logic              bscan_shift,
    input  logic              bscan_update,
    input  logic              bscan_mode
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned HW = W / 2;

    logic [2*W-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]  level_q, level_d;
    logic [2*W-1:0] rd_data_q;
    logic           rd_valid_q;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   hold_q, hold_d;
    logic           toggle_q, toggle_d;
    logic           sdrmode_q;
    logic [W-1:0]   pad_out_q, pad_out_d;
    logic           pad_oe_q, pad_oe_d;

    logic [W-1:0]   rise_m, fall_m;
    logic           mode_chg, toggle_eff;
    logic           wr_due, wr_ok, pop;
    logic [2*W-1:0] wr_entry;

    always_comb begin
        rise_m = in_data[W-1:0];
        fall_m = in_data[2*W-1:W];
        if (!hw_enb) begin
            rise_m[W-1:HW] = '0;
            fall_m[W-1:HW] = '0;
        end
    end

    assign fifo_full  = (level_q == LW'(DEPTH));
    assign fifo_empty = (level_q == '0);
    assign pop        = rd_en & ~fifo_empty;

    // A mode switch discards any half-built single-rate pair, including on this very cycle.
    assign mode_chg   = (sdrmode != sdrmode_q);
    assign toggle_eff = toggle_q & ~mode_chg;

    always_comb begin
        wr_due   = 1'b0;
        wr_entry = '0;
        toggle_d = toggle_eff;
        hold_d   = mode_chg ? '0 : hold_q;
        if (in_valid) begin
            if (!sdrmode) begin
                wr_due   = 1'b1;
                wr_entry = {fall_m, rise_m};
            end else if (!toggle_eff) begin
                hold_d   = rise_m;
                toggle_d = 1'b1;
            end else begin
                wr_due   = 1'b1;
                wr_entry = {rise_m, hold_q};
                toggle_d = 1'b0;
            end
        end
    end

    // When full, a same-cycle pop frees the slot being written.
    assign wr_ok = wr_due & (~fifo_full | rd_en);

    always_comb begin
        ovf_d = ovf_q;
        if (wr_due && !wr_ok) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        level_d = level_q;
        unique case ({wr_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            hold_q     <= '0;
            toggle_q   <= 1'b0;
            sdrmode_q  <= 1'b0;
            pad_out_q  <= '0;
            pad_oe_q   <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= wr_entry;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_data_q <= mem_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end
            rd_valid_q <= pop;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            hold_q     <= hold_d;
            toggle_q   <= toggle_d;
            sdrmode_q  <= sdrmode;
            pad_out_q  <= pad_out_d;
            pad_oe_q   <= pad_oe_d;
        end
    end

`ifdef SDRAM_DQ_BSCAN_EN
    logic [W:0] sr_q, upd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            upd_q <= '0;
        end else if (bscan_clken) begin
            if (bscan_capture) begin
                sr_q <= {pin_outen, in_data[W-1:0]};
            end else if (bscan_shift) begin
                sr_q <= {sr_q[W-1:0], bscan_si};
            end
            if (bscan_update) begin
                upd_q <= sr_q;
            end
        end
    end

    assign bscan_so = sr_q[W];

    always_comb begin
        pad_out_d = pin_out;
        pad_oe_d  = pin_outen;
        if (bscan_mode) begin
            pad_out_d = upd_q[W-1:0];
            pad_oe_d  = upd_q[W];
        end
    end
`else
    logic unused_bscan;
    assign unused_bscan = ^{bscan_clken, bscan_capture, bscan_shift, bscan_update, bscan_mode};
    assign bscan_so     = bscan_si;

    always_comb begin
        pad_out_d = pin_out;
        pad_oe_d  = pin_outen;
    end
`endif

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign pad_out    = pad_out_q;
    assign pad_oe     = {W{pad_oe_q}};

endmodule

// File: tb/tb_sdram_dq_bank.sv
// Directed self-checking bench for sdram_dq_bank at W=8, DEPTH=4.
// Bscan chain scenarios run when SDRAM_DQ_BSCAN_EN is defined, pass-through otherwise.
module tb_sdram_dq_bank;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 3;

    logic            clk;
    logic            rst_n;
    logic [W-1:0]    pin_out;
    logic            pin_outen;
    logic            sdrmode;
    logic            hw_enb;
    logic            in_valid;
    logic [2*W-1:0]  in_data;
    logic            rd_en;
    logic [2*W-1:0]  rd_data;
    logic            rd_valid;
    logic            fifo_full;
    logic            fifo_empty;
    logic [LW-1:0]   fifo_level;
    logic            overflow;
    logic            clr_ovf;
    logic [W-1:0]    pad_out;
    logic [W-1:0]    pad_oe;
    logic            bscan_si;
    logic            bscan_so;
    logic            bscan_clken;
    logic            bscan_capture;
    logic            bscan_shift;
    logic            bscan_update;
    logic            bscan_mode;

    int n_checks;
    int n_fail;

    sdram_dq_bank #(
        .W     (W),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pin_out       (pin_out),
        .pin_outen     (pin_outen),
        .sdrmode       (sdrmode),
        .hw_enb        (hw_enb),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .clr_ovf       (clr_ovf),
        .pad_out       (pad_out),
        .pad_oe        (pad_oe),
        .bscan_si      (bscan_si),
        .bscan_so      (bscan_so),
        .bscan_clken   (bscan_clken),
        .bscan_capture (bscan_capture),
        .bscan_shift   (bscan_shift),
        .bscan_update  (bscan_update),
        .bscan_mode    (bscan_mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_level !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_flags: empty=%b full=%b level=%0d, want 1 0 0",
                     fifo_empty, fifo_full, fifo_level);
        end
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read: valid=%b data=%h ovf=%b, want 0 0000 0",
                     rd_valid, rd_data, overflow);
        end
        n_checks++;
        if (pad_out !== 8'h00 || pad_oe !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_pads: out=%h oe=%h, want 00 00", pad_out, pad_oe);
        end
    endtask

    task automatic test_ddr();
        logic [15:0] exp_d [2];
        exp_d[0] = 16'hA55A;
        exp_d[1] = 16'h1234;
        hw_enb   = 1'b1;
        sdrmode  = 1'b0;
        in_valid = 1'b1;
        in_data  = exp_d[0];
        tick();
        in_data  = exp_d[1];
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd2 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ddr_level2: level=%0d valid=%b, want 2 0", fifo_level, rd_valid);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_d[i]) begin
                n_fail++;
                $display("FAIL ddr_pop%0d: valid=%b data=%h, want 1 %h",
                         i, rd_valid, rd_data, exp_d[i]);
            end
        end
        rd_en = 1'b0;
        tick();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h1234 || fifo_level !== 3'd0
            || fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL ddr_drained: valid=%b data=%h level=%0d empty=%b, want 0 1234 0 1",
                     rd_valid, rd_data, fifo_level, fifo_empty);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || fifo_level !== 3'd0 || rd_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL ddr_empty_read: valid=%b level=%0d data=%h, want 0 0 1234",
                     rd_valid, fifo_level, rd_data);
        end
    endtask

    task automatic test_sdr_pack();
        sdrmode = 1'b1;
        hw_enb  = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 16'hEEF3;
        tick();
        n_checks++;
        if (fifo_level !== 3'd0) begin
            n_fail++;
            $display("FAIL sdr_first_held: level=%0d, want 0", fifo_level);
        end
        in_data = 16'hDD7C;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd1) begin
            n_fail++;
            $display("FAIL sdr_pair_written: level=%0d, want 1", fifo_level);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h0C03) begin
            n_fail++;
            $display("FAIL sdr_entry: valid=%b data=%h, want 1 0c03", rd_valid, rd_data);
        end
        sdrmode = 1'b0;
        hw_enb  = 1'b1;
        tick();
    endtask

    task automatic test_overflow();
        logic [15:0] exp_d [4];
        exp_d[0] = 16'h2222;
        exp_d[1] = 16'h3333;
        exp_d[2] = 16'h4444;
        exp_d[3] = 16'h6666;
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 16'h1111 * i;
            tick();
        end
        n_checks++;
        if (fifo_full !== 1'b1 || fifo_level !== 3'd4 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full: full=%b level=%0d ovf=%b, want 1 4 0",
                     fifo_full, fifo_level, overflow);
        end
        in_data = 16'h5555;
        tick();
        n_checks++;
        if (overflow !== 1'b1 || fifo_level !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_dropped: ovf=%b level=%0d, want 1 4", overflow, fifo_level);
        end
        in_data = 16'h6666;
        rd_en   = 1'b1;
        tick();
        in_valid = 1'b0;
        rd_en    = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd4 || rd_data !== 16'h1111 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_push_pop: level=%0d data=%h ovf=%b, want 4 1111 1",
                     fifo_level, rd_data, overflow);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%b, want 0", overflow);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_d[i]) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: valid=%b data=%h, want 1 %h",
                         i, rd_valid, rd_data, exp_d[i]);
            end
        end
        rd_en = 1'b0;
        tick();
        n_checks++;
        if (fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_empty_after: empty=%b, want 1", fifo_empty);
        end
    endtask

`ifdef SDRAM_DQ_BSCAN_EN
    task automatic test_bscan_capture_shift();
        logic [8:0] exp_so;
        exp_so        = 9'b1_1001_0110;
        in_data       = 16'h0096;
        pin_outen     = 1'b1;
        bscan_clken   = 1'b1;
        bscan_capture = 1'b1;
        bscan_si      = 1'b0;
        tick();
        bscan_capture = 1'b0;
        pin_outen     = 1'b0;
        bscan_shift   = 1'b1;
        for (int i = 8; i >= 0; i--) begin
            n_checks++;
            if (bscan_so !== exp_so[i]) begin
                n_fail++;
                $display("FAIL bscan_so_bit%0d: so=%b, want %b", i, bscan_so, exp_so[i]);
            end
            tick();
        end
        bscan_shift = 1'b0;
        n_checks++;
        if (bscan_so !== 1'b0) begin
            n_fail++;
            $display("FAIL bscan_flushed: so=%b, want 0", bscan_so);
        end
    endtask

    task automatic test_bscan_update();
        logic [8:0] vec;
        vec         = 9'h15A;
        bscan_shift = 1'b1;
        for (int i = 8; i >= 0; i--) begin
            bscan_si = vec[i];
            tick();
        end
        bscan_shift  = 1'b0;
        bscan_si     = 1'b0;
        bscan_update = 1'b1;
        tick();
        bscan_update = 1'b0;
        bscan_mode   = 1'b1;
        pin_out      = 8'h00;
        pin_outen    = 1'b0;
        tick();
        n_checks++;
        if (pad_out !== 8'h5A || pad_oe !== 8'hFF) begin
            n_fail++;
            $display("FAIL bscan_drive: out=%h oe=%h, want 5a ff", pad_out, pad_oe);
        end
        // capture with clken low must not disturb the chain (sr[8] stays 1)
        bscan_clken   = 1'b0;
        bscan_capture = 1'b1;
        tick();
        bscan_capture = 1'b0;
        n_checks++;
        if (bscan_so !== 1'b1) begin
            n_fail++;
            $display("FAIL bscan_clken_gate: so=%b, want 1", bscan_so);
        end
    endtask
`else
    task automatic test_bscan_bypass();
        bscan_si = 1'b1;
        #1;
        n_checks++;
        if (bscan_so !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_hi: so=%b, want 1", bscan_so);
        end
        bscan_si = 1'b0;
        #1;
        n_checks++;
        if (bscan_so !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_lo: so=%b, want 0", bscan_so);
        end
        bscan_mode  = 1'b1;
        bscan_clken = 1'b1;
        pin_out     = 8'h3C;
        pin_outen   = 1'b1;
        tick();
        n_checks++;
        if (pad_out !== 8'h3C || pad_oe !== 8'hFF) begin
            n_fail++;
            $display("FAIL bypass_pads: out=%h oe=%h, want 3c ff", pad_out, pad_oe);
        end
    endtask
`endif

    task automatic test_reset_mid_op();
        pin_out   = 8'h00;
        pin_outen = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'h0101 * (i + 1);
            tick();
        end
        in_valid = 1'b0;
        rd_en    = 1'b1;
        tick();
        rd_en = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd3 || overflow !== 1'b1 || rd_valid !== 1'b1
            || pad_oe !== 8'hFF) begin
            n_fail++;
            $display("FAIL rst_pre: level=%0d ovf=%b valid=%b oe=%h, want 3 1 1 ff",
                     fifo_level, overflow, rd_valid, pad_oe);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (fifo_empty !== 1'b1 || fifo_level !== 3'd0 || pad_oe !== 8'h00
            || overflow !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_async: empty=%b level=%0d oe=%h ovf=%b valid=%b data=%h",
                     fifo_empty, fifo_level, pad_oe, overflow, rd_valid, rd_data);
        end
        #1;
        rst_n     = 1'b1;
        pin_outen = 1'b0;
        tick();
        n_checks++;
        if (pad_oe !== 8'h00 || fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_after: oe=%h empty=%b, want 00 1", pad_oe, fifo_empty);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        pin_out       = '0;
        pin_outen     = 1'b0;
        sdrmode       = 1'b0;
        hw_enb        = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        rd_en         = 1'b0;
        clr_ovf       = 1'b0;
        bscan_si      = 1'b0;
        bscan_clken   = 1'b0;
        bscan_capture = 1'b0;
        bscan_shift   = 1'b0;
        bscan_update  = 1'b0;
        bscan_mode    = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_ddr();
        test_sdr_pack();
        test_overflow();
`ifdef SDRAM_DQ_BSCAN_EN
        test_bscan_capture_shift();
        test_bscan_update();
`else
        test_bscan_bypass();
`endif
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
